// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline registers.
package core_pkg;

  localparam int XLEN = 32;

  // Control word carried from decode into execute, MSB first.
  typedef struct packed {
    logic       RegWrite;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic       ALUSrc;
    logic [1:0] ResultSrc;
    logic [2:0] ALUControl;
    logic       Op5;
    logic       LoadByte;
  } ctrl_e_t;

  // A bubble carries no side effects: every control bit low.
  localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, used for bubble and other performance counts.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = &r_count;

  // Count up on inc, sticking at all-ones; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)                r_count <= '0;
    else if (inc && !w_at_max) r_count <= r_count + 1'b1;
  end

  assign count = r_count;

endmodule

// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register: decoded control word, operands, PC and register
// indices captured from decode and held for execute, with stall/flush and a
// saturating bubble counter.
module decode_execute_reg #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic            Op5D,
  input  logic            LoadByteD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic            Op5E,
  output logic            LoadByteE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            ValidE,
  output logic [CNTW-1:0] BubbleCnt
);

  import core_pkg::*;

  ctrl_e_t         w_ctrl_d;
  ctrl_e_t         r_ctrl;
  logic [XLEN-1:0] r_rd1, r_rd2, r_pc, r_pcp4, r_imm;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic            r_valid;
  logic            w_bubble;

  assign w_ctrl_d = '{RegWrite:   RegWriteD,
                      MemWrite:   MemWriteD,
                      Jump:       JumpD,
                      Branch:     BranchD,
                      ALUSrc:     ALUSrcD,
                      ResultSrc:  ResultSrcD,
                      ALUControl: ALUControlD,
                      Op5:        Op5D,
                      LoadByte:   LoadByteD};

  // Flush wins over stall; an unstalled load of an invalid slot is also a
  // bubble so that no side-effecting control can leak from a dead slot.
  assign w_bubble = FlushE | (~StallE & ~ValidD);

  // Slot update: reset > bubble > hold (stall) > load.
  always_ff @(posedge clk) begin
    if (!rst_n || w_bubble) begin
      r_ctrl  <= CTRL_BUBBLE;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_pc    <= '0;
      r_pcp4  <= '0;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else if (!StallE) begin
      r_ctrl  <= w_ctrl_d;
      r_rd1   <= RD1D;
      r_rd2   <= RD2D;
      r_pc    <= PCD;
      r_pcp4  <= PCPlus4D;
      r_imm   <= ImmExtD;
      r_rs1   <= Rs1D;
      r_rs2   <= Rs2D;
      r_rd    <= RdD;
      r_valid <= 1'b1;
    end
  end

  sat_counter #(.W(CNTW)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_bubble),
    .count (BubbleCnt)
  );

  assign RegWriteE   = r_ctrl.RegWrite;
  assign MemWriteE   = r_ctrl.MemWrite;
  assign JumpE       = r_ctrl.Jump;
  assign BranchE     = r_ctrl.Branch;
  assign ALUSrcE     = r_ctrl.ALUSrc;
  assign ResultSrcE  = r_ctrl.ResultSrc;
  assign ALUControlE = r_ctrl.ALUControl;
  assign Op5E        = r_ctrl.Op5;
  assign LoadByteE   = r_ctrl.LoadByte;
  assign RD1E        = r_rd1;
  assign RD2E        = r_rd2;
  assign PCE         = r_pc;
  assign PCPlus4E    = r_pcp4;
  assign ImmExtE     = r_imm;
  assign Rs1E        = r_rs1;
  assign Rs2E        = r_rs2;
  assign RdE         = r_rd;
  assign ValidE      = r_valid;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed bench for decode_execute_reg, built with a 3-bit bubble counter so
// saturation is reachable in a few cycles.
module tb_decode_execute_reg;
  import core_pkg::*;

  localparam int CNTW = 3;

  logic        clk = 1'b0;
  logic        rst_n, StallE, FlushE, ValidD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, Op5D, LoadByteD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, Op5E, LoadByteE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ValidE;
  logic [CNTW-1:0] BubbleCnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_execute_reg #(.XLEN(32), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .Op5D(Op5D), .LoadByteD(LoadByteD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .Op5E(Op5E), .LoadByteE(LoadByteE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE), .BubbleCnt(BubbleCnt)
  );

  typedef struct {
    string       name;
    bit          rst_n, stall, flush, valid;
    logic [11:0] ctrl;
    logic [31:0] rd1, pc;
    logic [4:0]  rd;
    logic [11:0] e_ctrl;
    logic [31:0] e_rd1, e_pc;
    logic [4:0]  e_rd;
    bit          e_valid;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  // The other datapath inputs are fixed functions of rd1/pc/rd so each vector
  // still exercises every field with distinct bit patterns.
  function automatic logic [31:0] f_rd2(logic [31:0] a);  return ~a; endfunction
  function automatic logic [31:0] f_imm(logic [31:0] a);  return {a[15:0], a[31:16]}; endfunction
  function automatic logic [4:0]  f_rs1(logic [4:0] r);   return r ^ 5'h1F; endfunction
  function automatic logic [4:0]  f_rs2(logic [4:0] r);   return r + 5'd1; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit fl, input bit v,
                       input logic [11:0] c, input logic [31:0] rd1,
                       input logic [31:0] pc, input logic [4:0] rd);
    ctrl_e_t cs;
    cs = ctrl_e_t'(c);
    rst_n = r; StallE = st; FlushE = fl; ValidD = v;
    RegWriteD = cs.RegWrite; MemWriteD = cs.MemWrite; JumpD = cs.Jump;
    BranchD = cs.Branch; ALUSrcD = cs.ALUSrc; ResultSrcD = cs.ResultSrc;
    ALUControlD = cs.ALUControl; Op5D = cs.Op5; LoadByteD = cs.LoadByte;
    RD1D = rd1; RD2D = f_rd2(rd1); PCD = pc; PCPlus4D = pc + 32'd4;
    ImmExtD = f_imm(rd1); Rs1D = f_rs1(rd); Rs2D = f_rs2(rd); RdD = rd;
  endtask

  // An invalid execute slot always holds all-zero contents.
  task automatic check_out(input string nm, input logic [11:0] ec, input logic [31:0] erd1,
                           input logic [31:0] epc, input logic [4:0] erd,
                           input bit ev, input int ecnt);
    ctrl_e_t act;
    act = '{RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
            ALUControlE, Op5E, LoadByteE};
    chk({nm, ".ctrl"},  {20'd0, act},      {20'd0, ec});
    chk({nm, ".RD1"},   RD1E,              erd1);
    chk({nm, ".RD2"},   RD2E,              ev ? f_rd2(erd1) : 32'd0);
    chk({nm, ".PC"},    PCE,               epc);
    chk({nm, ".PCP4"},  PCPlus4E,          ev ? epc + 32'd4 : 32'd0);
    chk({nm, ".Imm"},   ImmExtE,           ev ? f_imm(erd1) : 32'd0);
    chk({nm, ".Rs1"},   {27'd0, Rs1E},     {27'd0, ev ? f_rs1(erd) : 5'd0});
    chk({nm, ".Rs2"},   {27'd0, Rs2E},     {27'd0, ev ? f_rs2(erd) : 5'd0});
    chk({nm, ".Rd"},    {27'd0, RdE},      {27'd0, erd});
    chk({nm, ".Valid"}, {31'd0, ValidE},   {31'd0, ev});
    chk({nm, ".Cnt"},   {29'd0, BubbleCnt}, ecnt);
  endtask

  function automatic vec_t mk(string n, bit r, bit st, bit fl, bit v,
                              logic [11:0] c, logic [31:0] rd1, logic [31:0] pc,
                              logic [4:0] rd, logic [11:0] ec, logic [31:0] erd1,
                              logic [31:0] epc, logic [4:0] erd, bit ev, int ecnt);
    vec_t t;
    t.name = n; t.rst_n = r; t.stall = st; t.flush = fl; t.valid = v;
    t.ctrl = c; t.rd1 = rd1; t.pc = pc; t.rd = rd;
    t.e_ctrl = ec; t.e_rd1 = erd1; t.e_pc = epc; t.e_rd = erd;
    t.e_valid = ev; t.e_cnt = ecnt;
    return t;
  endfunction

  initial begin
    int cnt;
    //               name       rst st fl v  ctrl     rd1           pc        rd     ectrl    erd1          epc       erd    ev cnt
    tbl.push_back(mk("reset0",  0, 0, 1, 1, 12'hFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h1F, 12'h000, 32'h0,        32'h0,   5'd0,  0, 0));
    tbl.push_back(mk("reset1",  0, 1, 0, 1, 12'hFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h1F, 12'h000, 32'h0,        32'h0,   5'd0,  0, 0));
    tbl.push_back(mk("pass",    1, 0, 0, 1, 12'h808, 32'hDEADBEEF, 32'h0,   5'd5,  12'h808, 32'hDEADBEEF, 32'h0,   5'd5,  1, 0));
    tbl.push_back(mk("ld100",   1, 0, 0, 1, 12'h0A5, 32'h11111111, 32'h100, 5'd3,  12'h0A5, 32'h11111111, 32'h100, 5'd3,  1, 0));
    tbl.push_back(mk("stall1",  1, 1, 0, 1, 12'hFFF, 32'h22222222, 32'h104, 5'd9,  12'h0A5, 32'h11111111, 32'h100, 5'd3,  1, 0));
    tbl.push_back(mk("stall2",  1, 1, 0, 1, 12'hFFF, 32'h22222222, 32'h104, 5'd9,  12'h0A5, 32'h11111111, 32'h100, 5'd3,  1, 0));
    tbl.push_back(mk("stall3",  1, 1, 0, 1, 12'hFFF, 32'h22222222, 32'h104, 5'd9,  12'h0A5, 32'h11111111, 32'h100, 5'd3,  1, 0));
    tbl.push_back(mk("release", 1, 0, 0, 1, 12'hFFF, 32'h22222222, 32'h104, 5'd9,  12'hFFF, 32'h22222222, 32'h104, 5'd9,  1, 0));
    tbl.push_back(mk("flushst", 1, 1, 1, 1, 12'hFFF, 32'h33333333, 32'h108, 5'd12, 12'h000, 32'h0,        32'h0,   5'd0,  0, 1));
    tbl.push_back(mk("invalid", 1, 0, 0, 0, 12'hFFF, 32'h44444444, 32'h10C, 5'd7,  12'h000, 32'h0,        32'h0,   5'd0,  0, 2));
    tbl.push_back(mk("stallbub",1, 1, 0, 1, 12'hFFF, 32'h55555555, 32'h110, 5'd8,  12'h000, 32'h0,        32'h0,   5'd0,  0, 2));
    tbl.push_back(mk("ldfull",  1, 0, 0, 1, 12'hFFF, 32'hCAFEF00D, 32'h200, 5'd31, 12'hFFF, 32'hCAFEF00D, 32'h200, 5'd31, 1, 2));
    tbl.push_back(mk("stallinv",1, 1, 0, 0, 12'h000, 32'h66666666, 32'h204, 5'd4,  12'hFFF, 32'hCAFEF00D, 32'h200, 5'd31, 1, 2));

    drive(0, 0, 0, 0, 12'h000, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].stall, tbl[i].flush, tbl[i].valid,
            tbl[i].ctrl, tbl[i].rd1, tbl[i].pc, tbl[i].rd);
      @(posedge clk); #1;
      check_out(tbl[i].name, tbl[i].e_ctrl, tbl[i].e_rd1, tbl[i].e_pc,
                tbl[i].e_rd, tbl[i].e_valid, tbl[i].e_cnt);
    end

    // Ten back-to-back flushes drive the 3-bit counter into saturation.
    cnt = 2;
    for (int k = 0; k < 10; k++) begin
      drive(1, k[0], 1, 1, 12'hFFF, 32'h77777777, 32'h300, 5'd6);
      @(posedge clk); #1;
      cnt = (cnt < 7) ? cnt + 1 : 7;
      check_out($sformatf("satflush%0d", k), 12'h000, 32'h0, 32'h0, 5'd0, 0, cnt);
    end
    chk("sat.final", {29'd0, BubbleCnt}, 32'd7);

    // Reset arriving in the middle of a flush burst clears the counter.
    drive(0, 1, 1, 1, 12'hFFF, 32'h77777777, 32'h300, 5'd6);
    @(posedge clk); #1;
    check_out("rstflush", 12'h000, 32'h0, 32'h0, 5'd0, 0, 0);

    // First edge out of reset is an ordinary update: here a flush, count 1.
    drive(1, 0, 1, 1, 12'hFFF, 32'h77777777, 32'h300, 5'd6);
    @(posedge clk); #1;
    check_out("postrst", 12'h000, 32'h0, 32'h0, 5'd0, 0, 1);

    // Then a normal load, visible after exactly one edge.
    drive(1, 0, 0, 1, 12'h123, 32'h89ABCDEF, 32'h400, 5'd17);
    @(posedge clk); #1;
    check_out("postld", 12'h123, 32'h89ABCDEF, 32'h400, 5'd17, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
